// File: rtl/kalman_pkg.sv
// Shared widths, noise constants and FSM encoding for the Kalman channel scheduler.
package kalman_pkg;

    localparam int DW_DEF = 19;
    localparam int KW_DEF = 16;
    localparam int Q_DEF  = 6;
    localparam int R_DEF  = 65;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRED,
        ST_DIV,
        ST_UPD,
        ST_OUT
    } state_t;

endpackage

// File: rtl/kalman_serial_div.sv
// Restoring divider producing a KW-bit quotient in exactly KW cycles after start.
// The caller guarantees the upper DW dividend bits are below the divisor, so the
// quotient always fits in KW bits. done is high during the final iteration; the
// quotient register holds the result from the following cycle on.
module kalman_serial_div #(
    parameter int DW = 19,
    parameter int KW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DW+KW-1:0] dividend,
    input  logic [DW:0]      divisor,
    output logic             done,
    output logic [KW-1:0]    quotient
);
    localparam int CW = (KW > 1) ? $clog2(KW) : 1;

    logic [DW:0]   rem;
    logic [KW-1:0] low;
    logic [CW-1:0] cnt;
    logic          run;
    logic [DW+1:0] trial;
    logic          fits;
    logic [DW:0]   rem_next;

    // one restoring step: shift in the next dividend bit, subtract when it fits
    always_comb begin
        trial    = {rem, low[KW-1]};
        fits     = (trial >= {1'b0, divisor});
        rem_next = fits ? (trial[DW:0] - divisor) : trial[DW:0];
        done     = run && (cnt == '0);
    end

    // iteration registers; abort wins over a simultaneous start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            low      <= '0;
            cnt      <= '0;
            run      <= 1'b0;
            quotient <= '0;
        end else if (abort) begin
            run <= 1'b0;
        end else if (start) begin
            rem      <= {1'b0, dividend[DW+KW-1:KW]};
            low      <= dividend[KW-1:0];
            cnt      <= CW'(KW - 1);
            run      <= 1'b1;
            quotient <= '0;
        end else if (run) begin
            rem      <= rem_next;
            low      <= low << 1;
            quotient <= {quotient[KW-2:0], fits};
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/kalman_channel_scheduler.sv
// Round-robin time-sharing of one scalar Kalman update datapath across NCH channels.
//   state | meaning
//   IDLE  | wait for a pending sample, grant round-robin, latch sample and channel state
//   PRED  | P = LastP + Q (saturating), start the gain divide
//   DIV   | KW-cycle restoring divide Kg = (P << KW) / (P + R)
//   UPD   | apply gain, commit LastP/LastOut, load result
//   OUT   | hold result until the consumer takes it
module kalman_channel_scheduler
    import kalman_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = DW_DEF,
    parameter int KW  = KW_DEF,
    parameter int Q   = Q_DEF,
    parameter int R   = R_DEF,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [NCH-1:0]    s_valid,
    input  logic [NCH*DW-1:0] s_data,
    output logic [NCH-1:0]    s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CHW-1:0]    m_chan,
    output logic [DW-1:0]     m_data,
    output logic              busy
);
    state_t           state, state_nxt;
    logic [NCH-1:0]   pend;
    logic [DW-1:0]    buf_x    [NCH];
    logic [DW-1:0]    last_p   [NCH];
    logic [DW-1:0]    last_out [NCH];
    logic [CHW-1:0]   rr, cur_ch, grant_ch;
    logic             grant_vld;
    logic [DW-1:0]    cur_x, cur_lo, cur_lp, p_reg;
    logic [DW:0]      p_sum;
    logic [DW-1:0]    p_pred, d, adj, out_new, lastp_new;
    logic [KW-1:0]    kg, p_keep;
    logic [DW+KW-1:0] prod_g, prod_p;
    logic             div_done;
    logic [NCH-1:0]   grant_mask;

    assign s_ready = ~pend;
    assign busy    = (state != ST_IDLE);

    // first pending channel at or after the rr pointer, wrapping
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_vld && pend[(int'(rr) + i) % NCH]) begin
                grant_vld = 1'b1;
                grant_ch  = CHW'((int'(rr) + i) % NCH);
            end
        end
        grant_mask = (state == ST_IDLE && grant_vld) ? (NCH'(1) << grant_ch) : '0;
    end

    // predict and update arithmetic; |x-LastOut| keeps every product unsigned
    always_comb begin
        p_sum     = {1'b0, cur_lp} + (DW+1)'(Q);
        p_pred    = p_sum[DW] ? '1 : p_sum[DW-1:0];
        d         = (cur_x > cur_lo) ? (cur_x - cur_lo) : (cur_lo - cur_x);
        prod_g    = (DW+KW)'(kg) * (DW+KW)'(d);
        adj       = DW'(prod_g >> KW);
        out_new   = (cur_x > cur_lo) ? (cur_lo + adj) : (cur_lo - adj);
        p_keep    = {KW{1'b1}} - kg;
        prod_p    = (DW+KW)'(p_keep) * (DW+KW)'(p_reg);
        lastp_new = DW'(prod_p >> KW);
    end

    kalman_serial_div #(.DW(DW), .KW(KW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state == ST_PRED),
        .abort    (flush),
        .dividend ({p_pred, {KW{1'b0}}}),
        .divisor  ({1'b0, p_pred} + (DW+1)'(R)),
        .done     (div_done),
        .quotient (kg)
    );

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_vld) state_nxt = ST_PRED;
            ST_PRED: state_nxt = ST_DIV;
            ST_DIV:  if (div_done) state_nxt = ST_UPD;
            ST_UPD:  state_nxt = ST_OUT;
            ST_OUT:  if (m_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state register; flush aborts any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= ST_IDLE;
        else if (flush) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // input slots: capture on handshake, release on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int i = 0; i < NCH; i++) buf_x[i] <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            pend <= (pend | (s_valid & ~pend)) & ~grant_mask;
            for (int i = 0; i < NCH; i++) begin
                if (s_valid[i] && !pend[i]) buf_x[i] <= s_data[i*DW +: DW];
            end
        end
    end

    // per-channel filter state, written only when an update completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < NCH; i++) begin
                last_p[i]   <= '0;
                last_out[i] <= '0;
            end
        end else if (state == ST_UPD) begin
            last_p[cur_ch]   <= lastp_new;
            last_out[cur_ch] <= out_new;
        end
    end

    // operation context latched at grant, predicted P latched in PRED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= '0;
            cur_ch <= '0;
            cur_x  <= '0;
            cur_lo <= '0;
            cur_lp <= '0;
            p_reg  <= '0;
        end else if (!flush) begin
            if (state == ST_IDLE && grant_vld) begin
                cur_ch <= grant_ch;
                cur_x  <= buf_x[grant_ch];
                cur_lo <= last_out[grant_ch];
                cur_lp <= last_p[grant_ch];
                rr     <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
            end
            if (state == ST_PRED) p_reg <= p_pred;
        end
    end

    // result port: loaded in UPD, held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_chan  <= '0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (state == ST_UPD) begin
            m_valid <= 1'b1;
            m_chan  <= cur_ch;
            m_data  <= out_new;
        end else if (state == ST_OUT && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
